// File: rtl/line_backing_mem_pkg.sv
// Shared types and constants for the line-granular backing memory model.
// Holds the controller FSM encoding, the data word width and a counter sizing helper.
package line_backing_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width able to hold max(a, b) - 1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line-wide storage: one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge, read is same-cycle.
// Backpressure: none, every write enable is honoured.
module line_mem_array #(
  parameter int LINE_W   = 256,
  parameter int ADDR_LEN = 8
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ADDR_LEN-1:0] wr_addr,
  input  logic [LINE_W-1:0]   wr_dat,
  input  logic [ADDR_LEN-1:0] rd_addr,
  output logic [LINE_W-1:0]   rd_dat
);

  // Contents start at zero and are deliberately untouched by reset.
  logic [LINE_W-1:0] mem [2**ADDR_LEN] = '{default: '0};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/line_backing_mem.sv
// Slow line-granular backing memory with fixed read/write latencies.
// Latency: gnt pulses RD_CYCLE / WR_CYCLE cycles after the request is accepted.
// Backpressure: requests are level, held until gnt; inputs are ignored while busy.
module line_backing_mem
  import line_backing_mem_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 8,
  parameter int RD_CYCLE      = 50,
  parameter int WR_CYCLE      = 50
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ADDR_LEN-1:0]                   addr,
  input  logic                                  rd_req,
  input  logic                                  wr_req,
  input  logic [(2**LINE_ADDR_LEN)*WORD_W-1:0]  wr_line,
  output logic [(2**LINE_ADDR_LEN)*WORD_W-1:0]  rd_line,
  output logic                                  gnt
);

  localparam int LINE_W = (2**LINE_ADDR_LEN) * WORD_W;
  localparam int CNT_W  = cnt_width(RD_CYCLE, WR_CYCLE);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_LEN-1:0] lat_addr;
  logic [LINE_W-1:0]   lat_line;
  logic                op_wr;
  logic                mem_we;
  logic [LINE_W-1:0]   mem_rd_dat;

  // Commit happens on the edge leaving DONE; a reset on that edge cancels it.
  assign mem_we = (state == DONE) && op_wr && !rst;

  line_mem_array #(
    .LINE_W   (LINE_W),
    .ADDR_LEN (ADDR_LEN)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (lat_addr),
    .wr_dat  (lat_line),
    .rd_addr (lat_addr),
    .rd_dat  (mem_rd_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt      <= 1'b0;
      rd_line  <= '0;
      op_wr    <= 1'b0;
      lat_addr <= '0;
      lat_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          gnt <= 1'b0;
          if (wr_req) begin
            lat_addr <= addr;
            lat_line <= wr_line;
            op_wr    <= 1'b1;
            cnt      <= CNT_W'(WR_CYCLE - 1);
            state    <= BUSY;
          end else if (rd_req) begin
            lat_addr <= addr;
            op_wr    <= 1'b0;
            cnt      <= CNT_W'(RD_CYCLE - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
            gnt   <= 1'b1;
            if (!op_wr) begin
              rd_line <= mem_rd_dat;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_backing_mem.sv
// Self-checking bench for line_backing_mem against an array-based memory model.
module tb_line_backing_mem;

  localparam int RD_C = 4;
  localparam int WR_C = 3;
  localparam int LA   = 3;
  localparam int AL   = 8;

  typedef logic [255:0] line_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AL-1:0] addr;
  logic          rd_req;
  logic          wr_req;
  line_t         wr_line;
  line_t         rd_line;
  logic          gnt;

  int checks   = 0;
  int failures = 0;

  line_t model [256];

  always #5 clk = ~clk;

  line_backing_mem #(
    .LINE_ADDR_LEN (LA),
    .ADDR_LEN      (AL),
    .RD_CYCLE      (RD_C),
    .WR_CYCLE      (WR_C)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .wr_line (wr_line),
    .rd_line (rd_line),
    .gnt     (gnt)
  );

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic line_t fill_line(input logic [31:0] w);
    line_t l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = w;
    return l;
  endfunction

  // Drives a request at a negedge and holds it until gnt; lat is cycles from acceptance edge to gnt.
  task automatic do_op(input bit w, input bit r, input logic [AL-1:0] a, input line_t d,
                       input bit scramble, output int lat, output line_t rdl);
    int  n;
    bit  seen;
    wr_req = w; rd_req = r; addr = a; wr_line = d;
    lat = -1; rdl = '0; n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (gnt) begin
        seen = 1; lat = n - 1; rdl = rd_line;
      end else if (scramble) begin
        addr = AL'($urandom); wr_line = rand_line();
      end
    end
    wr_req = 0; rd_req = 0;
  endtask

  task automatic test_reset();
    rst = 1; rd_req = 0; wr_req = 0; addr = '0; wr_line = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
    checks++;
    if (rd_line !== '0) begin failures++; $display("FAIL reset_rd_line got=%h exp=0", rd_line); end
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== 1'b0) begin failures++; $display("FAIL idle_gnt got=%b exp=0", gnt); end
  endtask

  task automatic test_write_read();
    int lat; line_t l, rdl;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'hA0 + i;
    do_op(1, 0, 8'h12, l, 0, lat, rdl);
    model[8'h12] = l;
    checks++;
    if (lat !== WR_C) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WR_C); end
    @(negedge clk);
    do_op(0, 1, 8'h12, '0, 0, lat, rdl);
    checks++;
    if (lat !== RD_C) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, RD_C); end
    checks++;
    if (rdl !== model[8'h12]) begin failures++; $display("FAIL rd_data_12 got=%h exp=%h", rdl, model[8'h12]); end
  endtask

  task automatic test_unwritten();
    int lat; line_t rdl;
    @(negedge clk);
    do_op(0, 1, 8'hFF, '0, 0, lat, rdl);
    checks++;
    if (rdl !== '0) begin failures++; $display("FAIL rd_unwritten got=%h exp=0", rdl); end
    repeat (3) @(negedge clk);
    checks++;
    if (rd_line !== '0) begin failures++; $display("FAIL rd_hold_idle got=%h exp=0", rd_line); end
    do_op(1, 0, 8'h33, fill_line(32'h1234_5678), 0, lat, rdl);
    model[8'h33] = fill_line(32'h1234_5678);
    @(negedge clk);
    checks++;
    if (rd_line !== '0) begin failures++; $display("FAIL rd_hold_write got=%h exp=0", rd_line); end
  endtask

  task automatic test_priority();
    int lat; line_t rdl;
    @(negedge clk);
    do_op(1, 1, 8'h05, fill_line(32'h55), 0, lat, rdl);
    model[8'h05] = fill_line(32'h55);
    checks++;
    if (lat !== WR_C) begin failures++; $display("FAIL prio_latency got=%0d exp=%0d", lat, WR_C); end
    @(negedge clk);
    do_op(0, 1, 8'h05, '0, 0, lat, rdl);
    checks++;
    if (rdl !== model[8'h05]) begin failures++; $display("FAIL prio_data got=%h exp=%h", rdl, model[8'h05]); end
  endtask

  task automatic test_ignore_changes();
    int lat, pulses; line_t rdl;
    @(negedge clk);
    wr_req = 1; addr = 8'h01; wr_line = fill_line(32'hDEAD);
    @(negedge clk);
    wr_req = 0; addr = 8'h02; wr_line = rand_line();
    model[8'h01] = fill_line(32'hDEAD);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt) pulses++;
    end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL ignore_gnt_pulses got=%0d exp=1", pulses); end
    do_op(0, 1, 8'h01, '0, 0, lat, rdl);
    checks++;
    if (rdl !== model[8'h01]) begin failures++; $display("FAIL ignore_data_01 got=%h exp=%h", rdl, model[8'h01]); end
    @(negedge clk);
    do_op(0, 1, 8'h02, '0, 0, lat, rdl);
    checks++;
    if (rdl !== model[8'h02]) begin failures++; $display("FAIL ignore_data_02 got=%h exp=%h", rdl, model[8'h02]); end
  endtask

  task automatic test_reset_abort();
    int lat, pulses; line_t rdl;
    @(negedge clk);
    wr_req = 1; addr = 8'h07; wr_line = fill_line(32'hBAD0_0007);
    @(negedge clk);
    rst = 1; wr_req = 0; rd_req = 1;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (gnt) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL abort_gnt_in_reset got=%0d exp=0", pulses); end
    checks++;
    if (rd_line !== '0) begin failures++; $display("FAIL abort_rd_line_reset got=%h exp=0", rd_line); end
    rst = 0;
    do_op(0, 1, 8'h07, '0, 0, lat, rdl);
    checks++;
    if (lat !== RD_C) begin failures++; $display("FAIL abort_held_rd_latency got=%0d exp=%0d", lat, RD_C); end
    checks++;
    if (rdl !== model[8'h07]) begin failures++; $display("FAIL abort_data_07 got=%h exp=%h", rdl, model[8'h07]); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] hist;
    int          n_gnt;
    bit          rd_issued;
    line_t       l, rdl;
    l = rand_line();
    hist = '0; n_gnt = 0; rd_issued = 0; rdl = '0;
    @(negedge clk);
    wr_req = 1; addr = 8'h10; wr_line = l;
    model[8'h10] = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hist[i] = gnt;
      if (rd_issued && !rd_req) begin end
      if (gnt) begin
        n_gnt++;
        if (n_gnt == 1) wr_req = 0;
        if (n_gnt == 2) begin rd_req = 0; rdl = rd_line; end
      end else if (n_gnt == 1 && !rd_issued) begin
        rd_req = 1; addr = 8'h10; rd_issued = 1;
      end
    end
    checks++;
    if (n_gnt !== 2) begin failures++; $display("FAIL b2b_gnt_count got=%0d exp=2", n_gnt); end
    checks++;
    if (hist[WR_C] !== 1'b1 || hist[WR_C + 2 + RD_C] !== 1'b1) begin
      failures++; $display("FAIL b2b_gnt_timing got=%b exp bits %0d and %0d set", hist, WR_C, WR_C + 2 + RD_C);
    end
    checks++;
    if (rdl !== model[8'h10]) begin failures++; $display("FAIL b2b_data got=%h exp=%h", rdl, model[8'h10]); end
  endtask

  task automatic test_random();
    int lat; line_t rdl, d; bit w, r; logic [AL-1:0] a;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = AL'($urandom_range(0, 15));
      w = $urandom_range(0, 1);
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      d = rand_line();
      do_op(w, r, a, d, 1, lat, rdl);
      checks++;
      if (lat !== (w ? WR_C : RD_C)) begin
        failures++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", k, lat, w ? WR_C : RD_C);
      end
      if (w) begin
        model[a] = d;
      end else begin
        checks++;
        if (rdl !== model[a]) begin failures++; $display("FAIL rand_rd_data op=%0d addr=%h got=%h exp=%h", k, a, rdl, model[a]); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = '0;
    test_reset();
    test_write_read();
    test_unwritten();
    test_priority();
    test_ignore_changes();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_backing_mem.md
LINE_BACKING_MEM -- requirements
Module: line_backing_mem

Interface
REQ-001 SHALL have parameter LINE_ADDR_LEN, default 3, log2 of 32-bit words per line.
REQ-002 SHALL have parameter ADDR_LEN, default 8, line-address width; depth = 2^ADDR_LEN lines.
REQ-003 SHALL have parameter RD_CYCLE, default 50, read latency in cycles; legal range >=1.
REQ-004 SHALL have parameter WR_CYCLE, default 50, write latency in cycles; legal range >=1.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port addr  input  ADDR_LEN  line address, qualified by rd_req/wr_req.
REQ-008 SHALL have port rd_req  input  1  line-read request, level, held until gnt.
REQ-009 SHALL have port wr_req  input  1  line-write request, level, held until gnt.
REQ-010 SHALL have port wr_line  input  2^LINE_ADDR_LEN x 32  write data line.
REQ-011 SHALL have port rd_line  output  2^LINE_ADDR_LEN x 32  read data line.
REQ-012 SHALL have port gnt  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 In IDLE with wr_req=1 at a rising edge, SHALL latch addr, wr_line and op=write, load counter with WR_CYCLE-1, enter BUSY.
REQ-015 In IDLE with rd_req=1 and wr_req=0, SHALL latch addr and op=read, load counter with RD_CYCLE-1, enter BUSY.
REQ-016 When rd_req and wr_req are both 1 in IDLE, write SHALL take priority; the read SHALL not be served.
REQ-017 In BUSY, counter SHALL decrement each cycle; at count 0, SHALL enter DONE on the next edge.
REQ-018 gnt SHALL be 1 in exactly the DONE cycle and 0 in every other cycle. Request sampled at edge t yields gnt high in cycle t+RD_CYCLE (read) or t+WR_CYCLE (write).
REQ-019 DONE SHALL always return to IDLE on the next edge. A request seen in the first IDLE cycle after DONE SHALL be accepted, so back-to-back write-then-read works with no idle gap.
REQ-020 Read: rd_line SHALL present the line at the latched address during the DONE cycle. It SHALL hold that value until the next read reaches DONE.
REQ-021 Write: the array line at the latched address SHALL be updated with the latched wr_line at the edge ending DONE.
REQ-022 Changes to addr, wr_line, rd_req and wr_req while in BUSY or DONE SHALL be ignored.
REQ-023 Requests deasserted before gnt SHALL NOT abort the operation; it completes and pulses gnt.
REQ-024 With no request in IDLE, SHALL stay in IDLE with gnt=0.
REQ-025 Storage contents SHALL initialise to all-zero at time 0.
REQ-026 Address wrap SHALL not occur: every addr value maps to a unique line.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, counter=0, gnt=0, rd_line=all-zero, in any state, including mid-BUSY.
REQ-028 Reset SHALL abort an in-flight write with no array update, and SHALL NOT clear array contents.
REQ-029 A request held through reset SHALL be accepted at the first edge with rst=0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE/BUSY/DONE) and the 32-bit word width constant.
REQ-031 A single sub-module, line_mem_array, SHALL hold storage. It has one line-wide synchronous write port and one combinational line-wide read port. The FSM, counter and latches reside in line_backing_mem.
REQ-032 Counter width SHALL be sized from max(RD_CYCLE, WR_CYCLE).

Verification (bench overrides RD_CYCLE=4, WR_CYCLE=3, LINE_ADDR_LEN=3, ADDR_LEN=8)
REQ-033 Write addr=0x12, words 0..7 = 0xA0..0xA7, held to gnt -> gnt in exactly the 3rd cycle after acceptance. A following read of 0x12 -> gnt 4 cycles after acceptance with rd_line = 0xA0..0xA7.
REQ-034 Read of never-written addr=0xFF -> rd_line all zero at gnt. rd_line unchanged afterwards until the next read completes.
REQ-035 rd_req and wr_req both high, addr=0x05, wr_line=0x55 -> write latency of 3. A read of 0x05 afterwards returns 0x55 in all words.
REQ-036 Accept write of 0x01 (0xDEAD), change addr to 0x02 and drop wr_req in BUSY -> gnt still pulses once. 0x01 holds 0xDEAD; 0x02 is unchanged.
REQ-037 rst asserted 1 cycle after accepting a write to 0x07 -> gnt never pulses and 0x07 stays zero. The held rd_req is accepted on the first non-reset edge.
REQ-038 Write 0x10 followed by a read of 0x10 issued in the cycle after gnt -> the read is accepted immediately and returns the written data. gnt is high for exactly 2 non-adjacent cycles total.
